// File: rtl/spram_bx_adapter.sv
// rtl/spram_bx_adapter.sv - byte/half/word access adapter onto a 32-bit single-port RAM
// Optional one-word read buffer enabled by defining SPRAM_BX_RDBUF_EN.
module spram_bx_adapter #(
  parameter int              AW          = 17,
  parameter logic [AW-3:0]   BUF_RST_TAG = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req,
  output logic          rdy,
  input  logic          we,
  input  logic [1:0]    sz,
  input  logic [AW-1:0] ai,
  input  logic [31:0]   vi,
  output logic [31:0]   vo,
  output logic          ack,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-3:0] m_ai,
  output logic [3:0]    m_bmsk,
  output logic [31:0]   m_vi,
  input  logic [31:0]   m_vo
);

  typedef enum logic [1:0] {IDLE, HI, DONE} state_t;
  state_t state, state_nxt;

  function automatic logic [31:0] sz_mask(input logic [1:0] s);
    case (s)
      2'd0:    sz_mask = 32'h0000_00ff;
      2'd1:    sz_mask = 32'h0000_ffff;
      default: sz_mask = 32'hffff_ffff;
    endcase
  endfunction

  logic [1:0]    szn, off;
  logic [AW-3:0] w;
  logic [7:0]    nb, bmsk8;
  logic [63:0]   wrot, rd64;
  logic          split, accept, hit;
  logic [31:0]   rd_vo, hit_vo;

  logic          we_q, split_q;
  logic [1:0]    szn_q, off_q;
  logic [AW-3:0] w_q, w1_q;
  logic [3:0]    hi_bmsk_q;
  logic [31:0]   hi_vi_q, cap_q;

  assign szn = (sz == 2'd3) ? 2'd2 : sz;
  assign off = ai[1:0];
  assign w   = ai[AW-1:2];

  always_comb begin
    case (szn)
      2'd0:    nb = 8'h01;
      2'd1:    nb = 8'h03;
      default: nb = 8'h0f;
    endcase
  end

  // 8-bit lane mask: low nibble targets word W, high nibble spills into W+1
  assign bmsk8  = nb << off;
  assign split  = |bmsk8[7:4];
  assign wrot   = {32'b0, vi & sz_mask(szn)} << {off, 3'b000};
  assign accept = (state == IDLE) && req && !rst && !hit;

  assign rd64  = split_q ? {m_vo, cap_q} : {32'b0, m_vo};
  assign rd_vo = 32'(rd64 >> {off_q, 3'b000}) & sz_mask(szn_q);

`ifdef SPRAM_BX_RDBUF_EN
  logic          buf_v;
  logic [AW-3:0] buf_tag;
  logic [31:0]   buf_data;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      merge[8*i +: 8] = m[i] ? n[8*i +: 8] : o[8*i +: 8];
  endfunction

  assign hit    = buf_v && (state == IDLE) && req && !we && !split && (buf_tag == w) && !rst;
  assign hit_vo = 32'({32'b0, buf_data} >> {off, 3'b000}) & sz_mask(szn);

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_v    <= 1'b0;
      buf_tag  <= BUF_RST_TAG;
      buf_data <= '0;
    end else if (state == DONE && !we_q && !split_q) begin
      buf_v    <= 1'b1;
      buf_tag  <= w_q;
      buf_data <= m_vo;
    end else if (accept && we && buf_tag == w) begin
      buf_data <= merge(buf_data, wrot[31:0], bmsk8[3:0]);
    end else if (state == HI && we_q && buf_tag == w1_q) begin
      buf_data <= merge(buf_data, hi_vi_q, hi_bmsk_q);
    end
  end
`else
  logic [AW-3:0] unused_buf_rst_tag;
  assign unused_buf_rst_tag = BUF_RST_TAG;
  assign hit    = 1'b0;
  assign hit_vo = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      split_q   <= 1'b0;
      szn_q     <= '0;
      off_q     <= '0;
      w_q       <= '0;
      w1_q      <= '0;
      hi_bmsk_q <= '0;
      hi_vi_q   <= '0;
      cap_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        we_q      <= we;
        split_q   <= split;
        szn_q     <= szn;
        off_q     <= off;
        w_q       <= w;
        w1_q      <= w + {{(AW-3){1'b0}}, 1'b1};
        hi_bmsk_q <= bmsk8[7:4];
        hi_vi_q   <= wrot[63:32];
      end
      if (state == HI) cap_q <= m_vo;
    end
  end

  // rst gates every RAM cycle so an interrupted split never reaches W+1
  always_comb begin
    state_nxt = state;
    rdy       = (state == IDLE);
    ack       = 1'b0;
    vo        = '0;
    m_en      = 1'b0;
    m_we      = 1'b0;
    m_ai      = '0;
    m_bmsk    = '0;
    m_vi      = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (hit) begin
            ack = 1'b1;
            vo  = hit_vo;
          end else if (req) begin
            m_en      = 1'b1;
            m_we      = we;
            m_ai      = w;
            m_bmsk    = we ? bmsk8[3:0] : 4'b0;
            m_vi      = we ? wrot[31:0] : 32'b0;
            state_nxt = split ? HI : DONE;
          end
        end
        HI: begin
          m_en      = 1'b1;
          m_we      = we_q;
          m_ai      = w1_q;
          m_bmsk    = we_q ? hi_bmsk_q : 4'b0;
          m_vi      = we_q ? hi_vi_q : 32'b0;
          state_nxt = DONE;
        end
        DONE: begin
          ack       = 1'b1;
          vo        = we_q ? 32'b0 : rd_vo;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spram_bx_adapter.sv
// tb/tb_spram_bx_adapter.sv - directed vector bench for spram_bx_adapter with a behavioural RAM
module tb_spram_bx_adapter;

`ifdef SPRAM_BX_RDBUF_EN
  localparam bit HIT_EN = 1'b1;
`else
  localparam bit HIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, req, we, rdy, ack, m_en, m_we;
  logic [1:0]  sz;
  logic [16:0] ai;
  logic [31:0] vi, vo, m_vi, m_vo;
  logic [14:0] m_ai;
  logic [3:0]  m_bmsk;

  spram_bx_adapter #(.AW(17)) dut (
    .clk(clk), .rst(rst), .req(req), .rdy(rdy), .we(we), .sz(sz), .ai(ai), .vi(vi),
    .vo(vo), .ack(ack), .m_en(m_en), .m_we(m_we), .m_ai(m_ai), .m_bmsk(m_bmsk),
    .m_vi(m_vi), .m_vo(m_vo)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:32767];
  always @(posedge clk) begin
    if (m_en) begin
      if (m_we) begin
        for (int i = 0; i < 4; i++)
          if (m_bmsk[i]) mem[m_ai][8*i +: 8] <= m_vi[8*i +: 8];
      end else begin
        m_vo <= mem[m_ai];
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic        r_rdy0, r_rdy1, r_en0;
  logic [3:0]  r_bm0, r_bm1;
  logic [14:0] r_ai0, r_ai1;
  logic [31:0] r_vi0, r_vi1, r_vo;
  int          r_lat;

  task automatic access(input logic w, input logic [1:0] s, input logic [16:0] a,
                        input logic [31:0] d);
    @(posedge clk); #1;
    req = 1'b1; we = w; sz = s; ai = a; vi = d;
    @(negedge clk);
    r_rdy0 = rdy; r_en0 = m_en; r_bm0 = m_bmsk; r_ai0 = m_ai; r_vi0 = m_vi;
    r_lat = 99; r_vo = '0;
    r_bm1 = '0; r_ai1 = '0; r_vi1 = '0; r_rdy1 = 1'b0;
    if (ack) begin
      r_lat = 0;
      r_vo  = vo;
    end
    @(posedge clk); #1;
    req = 1'b0;
    if (r_lat != 0) begin
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) begin
          r_bm1 = m_bmsk; r_ai1 = m_ai; r_vi1 = m_vi; r_rdy1 = rdy;
        end
        if (ack) begin
          r_lat = c;
          r_vo  = vo;
          break;
        end
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [16:0] a;
    logic [31:0] d;
    int          lat;
    bit          bh;
    logic [3:0]  bm0;
    logic [14:0] ai0;
    logic [3:0]  bm1;
    logic [14:0] ai1;
    logic [31:0] v0m, v0e, v1m, v1e, vo;
  } vec_t;

  vec_t tv [0:14];
  int   elat;
  logic [31:0] buf_vo;

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; sz = '0; ai = '0; vi = '0;

    tv[0]  = '{1'b1, 2'd2, 17'h00000, 32'h00000000, 1, 1'b0, 4'hf, 15'h0000, 4'h0, 15'h0000, 32'hffffffff, 32'h00000000, 32'h0, 32'h0, 32'h0};
    tv[1]  = '{1'b1, 2'd0, 17'h00003, 32'h000000a5, 1, 1'b0, 4'h8, 15'h0000, 4'h0, 15'h0000, 32'hff000000, 32'ha5000000, 32'h0, 32'h0, 32'h0};
    tv[2]  = '{1'b0, 2'd0, 17'h00003, 32'h0,        1, 1'b0, 4'h0, 15'h0000, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h000000a5};
    tv[3]  = '{1'b1, 2'd2, 17'h00004, 32'h11223344, 1, 1'b0, 4'hf, 15'h0001, 4'h0, 15'h0000, 32'hffffffff, 32'h11223344, 32'h0, 32'h0, 32'h0};
    tv[4]  = '{1'b0, 2'd1, 17'h00006, 32'h0,        1, 1'b0, 4'h0, 15'h0001, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00001122};
    tv[5]  = '{1'b0, 2'd0, 17'h00005, 32'h0,        1, 1'b1, 4'h0, 15'h0001, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h00000033};
    tv[6]  = '{1'b1, 2'd2, 17'h00005, 32'hdeadbeef, 2, 1'b0, 4'he, 15'h0001, 4'h1, 15'h0002, 32'hffffff00, 32'hadbeef00, 32'h000000ff, 32'h000000de, 32'h0};
    tv[7]  = '{1'b0, 2'd2, 17'h00005, 32'h0,        2, 1'b0, 4'h0, 15'h0001, 4'h0, 15'h0002, 32'h0, 32'h0, 32'h0, 32'h0, 32'hdeadbeef};
    tv[8]  = '{1'b0, 2'd2, 17'h00004, 32'h0,        1, 1'b1, 4'h0, 15'h0001, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'hadbeef44};
    tv[9]  = '{1'b0, 2'd3, 17'h00004, 32'h0,        1, 1'b1, 4'h0, 15'h0001, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'hadbeef44};
    tv[10] = '{1'b1, 2'd1, 17'h1ffff, 32'h0000cafe, 2, 1'b0, 4'h8, 15'h7fff, 4'h1, 15'h0000, 32'hff000000, 32'hfe000000, 32'h000000ff, 32'h000000ca, 32'h0};
    tv[11] = '{1'b0, 2'd1, 17'h1ffff, 32'h0,        2, 1'b0, 4'h0, 15'h7fff, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000cafe};
    tv[12] = '{1'b0, 2'd2, 17'h00000, 32'h0,        1, 1'b0, 4'h0, 15'h0000, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'ha50000ca};
    tv[13] = '{1'b1, 2'd1, 17'h00002, 32'hffffbeef, 1, 1'b0, 4'hc, 15'h0000, 4'h0, 15'h0000, 32'hffff0000, 32'hbeef0000, 32'h0, 32'h0, 32'h0};
    tv[14] = '{1'b0, 2'd1, 17'h00001, 32'h0,        1, 1'b1, 4'h0, 15'h0000, 4'h0, 15'h0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000ef00};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 64'(rdy), 64'd1);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_vo", 64'(vo), 64'd0);
    chk("rst_m_en", 64'(m_en), 64'd0);
    chk("rst_m_we", 64'(m_we), 64'd0);
    chk("rst_m_bmsk", 64'(m_bmsk), 64'd0);
    chk("rst_m_ai", 64'(m_ai), 64'd0);
    chk("rst_m_vi", 64'(m_vi), 64'd0);

    for (int i = 0; i < 15; i++) begin
      access(tv[i].we, tv[i].sz, tv[i].a, tv[i].d);
      elat = (HIT_EN && tv[i].bh) ? 0 : tv[i].lat;
      chk($sformatf("v%0d_rdy", i), 64'(r_rdy0), 64'd1);
      chk($sformatf("v%0d_lat", i), 64'(r_lat), 64'(elat));
      if (elat > 0) begin
        chk($sformatf("v%0d_ai0", i), 64'(r_ai0), 64'(tv[i].ai0));
        chk($sformatf("v%0d_bm0", i), 64'(r_bm0), 64'(tv[i].bm0));
        chk($sformatf("v%0d_busy", i), 64'(r_rdy1), 64'd0);
      end
      if (tv[i].v0m != 0)
        chk($sformatf("v%0d_mvi0", i), 64'(r_vi0 & tv[i].v0m), 64'(tv[i].v0e));
      if (tv[i].lat == 2) begin
        chk($sformatf("v%0d_ai1", i), 64'(r_ai1), 64'(tv[i].ai1));
        chk($sformatf("v%0d_bm1", i), 64'(r_bm1), 64'(tv[i].bm1));
      end
      if (tv[i].v1m != 0)
        chk($sformatf("v%0d_mvi1", i), 64'(r_vi1 & tv[i].v1m), 64'(tv[i].v1e));
      if (!tv[i].we)
        chk($sformatf("v%0d_vo", i), 64'(r_vo), 64'(tv[i].vo));
    end

    // reset landing in the HI cycle of a split write
    access(1'b1, 2'd2, 17'h0000c, 32'h55667788);
    chk("pre_lat", 64'(r_lat), 64'd1);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; sz = 2'd2; ai = 17'h00009; vi = 32'h01020304;
    @(negedge clk);
    chk("int_lo_en", 64'(m_en), 64'd1);
    chk("int_lo_bmsk", 64'(m_bmsk), 64'he);
    chk("int_lo_ai", 64'(m_ai), 64'd2);
    @(posedge clk); #1;
    req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("int_rst_en", 64'(m_en), 64'd0);
    chk("int_rst_ack", 64'(ack), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("int_post_en", 64'(m_en), 64'd0);
    chk("int_post_ack", 64'(ack), 64'd0);
    chk("int_post_rdy", 64'(rdy), 64'd1);
    access(1'b0, 2'd2, 17'h0000c, 32'h0);
    chk("int_hi_vo", 64'(r_vo), 64'h55667788);
    access(1'b0, 2'd2, 17'h00008, 32'h0);
    chk("int_lo_vo", 64'(r_vo), 64'h020304de);

    // read buffer: repeated read, then a byte write into the buffered word
    access(1'b1, 2'd2, 17'h00010, 32'haabbccdd);
    access(1'b0, 2'd2, 17'h00010, 32'h0);
    chk("buf_rd1_lat", 64'(r_lat), 64'd1);
    chk("buf_rd1_vo", 64'(r_vo), 64'haabbccdd);
    access(1'b0, 2'd2, 17'h00010, 32'h0);
    chk("buf_rd2_lat", 64'(r_lat), HIT_EN ? 64'd0 : 64'd1);
    chk("buf_rd2_en", 64'(r_en0), HIT_EN ? 64'd0 : 64'd1);
    chk("buf_rd2_vo", 64'(r_vo), 64'haabbccdd);
    access(1'b1, 2'd0, 17'h00011, 32'h00000077);
    access(1'b0, 2'd2, 17'h00010, 32'h0);
    buf_vo = r_vo;
    chk("buf_rd3_lat", 64'(r_lat), HIT_EN ? 64'd0 : 64'd1);
    chk("buf_rd3_vo", 64'(buf_vo), 64'haabb77dd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/spram_bx_adapter.md
# spram_bx_adapter

Parametrised byte-addressable access adapter in front of the 32-bit single-port RAM, successor to the fixed 8-bit converter. It serves byte, half-word and word accesses at any byte alignment and splits lane-crossing accesses into two RAM cycles. It uses a req/rdy/ack handshake and has an optional one-word read buffer. It sits between the eForth core's data/fetch port and the 32-bit SPRAM macro.

## Interface
- AW, 17: byte address width; the RAM word address is AW-2 bits.
- BUF_RST_TAG, 0: tag loaded into the read buffer at reset. The buffer is invalid regardless of this value.
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  access request, sampled when rdy=1
- rdy  out  1  adapter can accept a request this cycle
- we  in  1  1=write, 0=read
- sz  in  2  access size: 0=byte, 1=half, 2=word, 3=reserved (treated as word)
- ai  in  AW  byte address (little-endian)
- vi  in  32  write data, right-justified
- vo  out  32  read data, right-justified, zero-extended; valid while ack=1
- ack  out  1  one-cycle completion pulse
- m_en  out  1  RAM cycle enable
- m_we  out  1  RAM write
- m_ai  out  AW-2  RAM word address
- m_bmsk  out  4  RAM byte-lane write mask
- m_vi  out  32  RAM write data (lane-aligned)
- m_vo  in  32  RAM read data, valid the cycle after a read issue

## Operation
- Lane mask for an access is bmsk = ((1<<(1<<sz))-1) << ai[1:0], computed 8 bits wide. Low nibble = word W = ai[AW-1:2]. High nibble = word W+1.
- Split access: high nibble is nonzero (half at offset 3; word at offset 1..3).
- W+1 wraps modulo 2^(AW-2): word 0x7FFF+1 maps to 0x0000.
- Write data is rotated left by 8*ai[1:0] bits. Lanes that spill over go to word W+1 in lanes 0..(high nibble).
- Read data: captured lanes are rotated right by 8*ai[1:0] and masked to the access size.
- FSM states:
  - IDLE: rdy=1. On req it issues the W cycle. A non-split access goes to DONE. A split access goes to HI.
  - HI: issues the W+1 cycle. For a read, it captures the lo-word lanes from m_vo. Then goes to DONE.
  - DONE: ack=1. For a read, vo is formed from the captured lanes plus the current m_vo. Then goes to IDLE.
- rdy=0 in HI and DONE. A req in those states is ignored; the requester holds req.
- sz=3 behaves exactly as sz=2.
- Reset: FSM goes to IDLE and ack=0. m_en, m_we, m_bmsk and vo go to 0, and rdy=1 from the cycle after rst. The buffer is invalidated. A split write interrupted by rst after the lo word never issues the hi word.

## Timing
- Reset values: rdy=1, ack=0, vo=0, m_en=0, m_we=0, m_bmsk=0, m_ai=0, m_vi=0.
- Accept at cycle T:
  - non-split: RAM cycle at T, ack at T+1.
  - split: RAM cycles at T and T+1, ack at T+2.
- Maximum throughput is one non-split access per 2 cycles. The earliest next accept is the cycle after ack.
- m_* outputs are driven combinationally from the request inputs in IDLE and from registers in HI.

## Configuration
- SPRAM_BX_RDBUF_EN defined:
  - A one-word read buffer {valid, tag=W, data} is filled by every non-split read at DONE.
  - A non-split read in IDLE whose W matches a valid tag completes with zero wait: ack=1 and vo valid in cycle T, m_en=0, and the FSM stays in IDLE.
  - A write to a buffered word updates the written lanes in the buffer (write-through).
  - Split reads bypass the buffer.
- Undefined: no buffer; every read follows the FSM timing above.

## Test plan
- Reset, then write byte 0xA5 at 0x00003, then read byte at 0x00003 -> m_bmsk=4'b1000, m_vi[31:24]=0xA5, ack at T+1; readback vo=0x000000A5.
- Write word 0x11223344 at 0x00004, read half at 0x00006 -> vo=0x00001122; read byte at 0x00005 -> vo=0x00000033.
- Write word 0xDEADBEEF at 0x00005 (split):
  - expected: cycle T m_ai=1, m_bmsk=1110; T+1 m_ai=2, m_bmsk=0001; ack at T+2.
  - read word at 0x00005 -> 0xDEADBEEF, ack at T+2.
- Write half 0xCAFE at byte 0x1FFFF -> second cycle m_ai=0x0000, m_bmsk=0001, m_vi[7:0]=0xCA (wrap).
- Assert rst in HI of a split write -> no m_en in following cycle, no ack, rdy=1 next cycle, hi word unchanged.
- With SPRAM_BX_RDBUF_EN: read word at 0x00010 twice -> second read ack in accept cycle with m_en=0. Then write byte 0x77 at 0x00011 and read again -> hit returns lane 1 = 0x77.
